// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// State encoding and a constant-function clog2 used to size pointers and counters.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester scanning upward from the pointer.
// Produces both a one-hot grant vector and the matching binary index.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] i_vld,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from the farthest offset down so the closest valid requester is written last and wins.
  always_comb begin
    int j;
    j        = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % N_REQ;
      if (i_vld[j]) begin
        o_onehot    = '0;
        o_onehot[j] = 1'b1;
        o_idx       = IDX_W'(j);
        o_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the async FIFO write port among N_REQ byte-stream requesters with atomic frames,
// round-robin between frames, W_FULL back-pressure and a MAX_LEN frame-length guard.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 2,
  parameter int MAX_LEN    = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req_vld,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]            i_req_last,
  output logic [N_REQ-1:0]            o_req_rdy,
  input  logic                        i_w_full,
  output logic                        o_w_inc,
  output logic [DATA_WIDTH-1:0]       o_w_data,
  output logic [N_REQ-1:0]            o_grant,
  output logic                        o_busy,
  output logic                        o_frame_err
);

  localparam int IDX_W = clog2(N_REQ);
  localparam int CNT_W = clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);
  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(N_REQ - 1);

  state_e             r_state, w_state_next;
  logic [N_REQ-1:0]   r_grant, w_grant_next;
  logic [IDX_W-1:0]   r_gidx, w_gidx_next;
  logic [IDX_W-1:0]   r_ptr, w_ptr_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_frame_err, w_frame_err_next;

  logic [N_REQ-1:0]   w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_accept;
  logic               w_last;

  fifo_wr_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_vld    (i_req_vld),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  always_comb begin
    w_state_next     = r_state;
    w_grant_next     = r_grant;
    w_gidx_next      = r_gidx;
    w_ptr_next       = r_ptr;
    w_cnt_next       = r_cnt;
    w_frame_err_next = 1'b0;
    o_req_rdy        = '0;
    o_w_inc          = 1'b0;
    o_w_data         = '0;
    w_accept         = 1'b0;
    w_last           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_next = ST_XFER;
          w_grant_next = w_pick_onehot;
          w_gidx_next  = w_pick_idx;
          w_cnt_next   = '0;
        end
      end
      ST_XFER: begin
        // Ready tracks only W_FULL, so a write is never issued into a full FIFO.
        o_req_rdy = r_grant & {N_REQ{~i_w_full}};
        o_w_data  = i_req_data[r_gidx*DATA_WIDTH +: DATA_WIDTH];
        w_accept  = i_req_vld[r_gidx] & ~i_w_full;
        w_last    = i_req_last[r_gidx];
        o_w_inc   = w_accept;
        if (w_accept) begin
          if (w_last || (r_cnt == LAST_CNT)) begin
            w_state_next     = ST_IDLE;
            w_grant_next     = '0;
            w_cnt_next       = '0;
            w_ptr_next       = (r_gidx == TOP_IDX) ? '0 : r_gidx + 1'b1;
            w_frame_err_next = ~w_last;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_gidx      <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_gidx      <= w_gidx_next;
      r_ptr       <= w_ptr_next;
      r_cnt       <= w_cnt_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  assign o_grant     = r_grant;
  assign o_busy      = (r_state == ST_XFER);
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios then random traffic, every cycle checked
// against a frame-level reference model of owner, byte count and rotating priority.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 2;
  localparam int ML = 4;

  logic           clk;
  logic           i_rst;
  logic [NR-1:0]  i_req_vld;
  logic [NR*DW-1:0] i_req_data;
  logic [NR-1:0]  i_req_last;
  logic [NR-1:0]  o_req_rdy;
  logic           i_w_full;
  logic           o_w_inc;
  logic [DW-1:0]  o_w_data;
  logic [NR-1:0]  o_grant;
  logic           o_busy;
  logic           o_frame_err;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .N_REQ      (NR),
    .MAX_LEN    (ML)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req_vld   (i_req_vld),
    .i_req_data  (i_req_data),
    .i_req_last  (i_req_last),
    .o_req_rdy   (o_req_rdy),
    .i_w_full    (i_w_full),
    .o_w_inc     (o_w_inc),
    .o_w_data    (o_w_data),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source queues: {last, data} per byte.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] exp_fifo[$];
  logic [7:0] dut_fifo[$];

  bit   en0, en1, full_r, rst_r;
  int   n_cmp, n_fail;
  int   cyc;

  // Reference model: who owns the port, bytes taken in this frame, who has priority.
  int   m_owner;
  int   m_cnt;
  int   m_prio;
  bit   m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_frame(input int r, input int len, input bit with_last, input logic [7:0] base);
    for (int b = 0; b < len; b++) begin
      logic [8:0] e;
      e = {(with_last && (b == len - 1)), 8'(base + 8'(b))};
      if (r == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic step();
    logic [NR-1:0] vld, last, exp_grant, exp_rdy;
    logic [7:0]    d0, d1, exp_data;
    bit            exp_inc, acc, found;
    @(negedge clk);
    cyc++;
    d0 = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    d1 = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    vld[0]  = en0 && (q0.size() > 0);
    vld[1]  = en1 && (q1.size() > 0);
    last[0] = (q0.size() > 0) ? q0[0][8] : 1'b0;
    last[1] = (q1.size() > 0) ? q1[0][8] : 1'b0;
    i_req_vld  = vld;
    i_req_last = last;
    i_req_data = {d1, d0};
    i_w_full   = full_r;
    i_rst      = rst_r;
    #1;
    exp_grant = '0;
    exp_rdy   = '0;
    exp_inc   = 1'b0;
    exp_data  = 8'h00;
    if (m_owner >= 0) begin
      exp_grant[m_owner] = 1'b1;
      exp_rdy[m_owner]   = !full_r;
      exp_inc            = vld[m_owner] && !full_r;
      exp_data           = (m_owner == 0) ? d0 : d1;
    end
    chk("grant",     32'(o_grant),     32'(exp_grant));
    chk("busy",      32'(o_busy),      32'(m_owner >= 0));
    chk("req_rdy",   32'(o_req_rdy),   32'(exp_rdy));
    chk("w_inc",     32'(o_w_inc),     32'(exp_inc));
    chk("w_data",    32'(o_w_data),    32'(exp_data));
    chk("frame_err", 32'(o_frame_err), 32'(m_err));
    if (o_w_inc) dut_fifo.push_back(o_w_data);
    if (exp_inc) exp_fifo.push_back(exp_data);
    acc = exp_inc;
    if (acc) begin
      if (m_owner == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
    end
    // Model state advance for the coming clock edge.
    if (rst_r) begin
      m_owner = -1; m_cnt = 0; m_prio = 0; m_err = 0;
    end else if (m_owner < 0) begin
      m_err = 0;
      found = 0;
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_prio + k) % NR;
        if (!found && vld[j]) begin
          m_owner = j;
          m_cnt   = 0;
          found   = 1;
        end
      end
    end else begin
      m_err = 0;
      if (acc) begin
        m_cnt++;
        if (last[m_owner] || m_cnt == ML) begin
          m_err   = !last[m_owner];
          m_prio  = (m_owner + 1) % NR;
          m_owner = -1;
          m_cnt   = 0;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    m_owner = -1; m_cnt = 0; m_prio = 0; m_err = 0;
    en0 = 1; en1 = 1; full_r = 0; rst_r = 1;
    i_rst = 1'b1; i_req_vld = '0; i_req_last = '0; i_req_data = '0; i_w_full = 1'b0;
    repeat (2) @(posedge clk);
    run(2);
    rst_r = 0;
    run(2);

    // 1: single 3-byte frame from req0
    q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
    run(7);

    // 2: both requesters stream 2-byte frames
    for (int f = 0; f < 2; f++) begin
      push_frame(0, 2, 1, 8'h10 + 8'(f * 16));
      push_frame(1, 2, 1, 8'h50 + 8'(f * 16));
    end
    run(16);

    // 3: W_FULL stall after the first byte
    push_frame(0, 3, 1, 8'h30);
    run(2);
    full_r = 1;
    run(4);
    full_r = 0;
    run(5);

    // 4: 6 bytes without LAST hit the length guard
    push_frame(1, 6, 0, 8'h60);
    run(12);

    // 5: reset mid-frame, then contention after reset
    push_frame(0, 3, 1, 8'h70);
    run(2);
    rst_r = 1;
    run(1);
    rst_r = 0;
    push_frame(1, 1, 1, 8'h7F);
    run(10);

    // 6: granted requester stalls VLD while the other waits
    push_frame(0, 3, 1, 8'h80);
    push_frame(1, 2, 1, 8'h90);
    run(2);
    en0 = 0;
    run(5);
    en0 = 1;
    run(10);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      if (q0.size() < 3) push_frame(0, $urandom_range(1, 6), ($urandom_range(0, 9) < 8), 8'($urandom));
      if (q1.size() < 3) push_frame(1, $urandom_range(1, 6), ($urandom_range(0, 9) < 8), 8'($urandom));
      en0    = ($urandom_range(0, 3) != 0);
      en1    = ($urandom_range(0, 3) != 0);
      full_r = ($urandom_range(0, 6) == 0);
      rst_r  = ($urandom_range(0, 199) == 0);
      step();
    end
    en0 = 1; en1 = 1; full_r = 0; rst_r = 0;
    run(60);

    chk("fifo_count", 32'(dut_fifo.size()), 32'(exp_fifo.size()));
    chk("src_empty",  32'(q0.size() + q1.size()), 32'd0);
    for (int i = 0; i < exp_fifo.size() && i < dut_fifo.size(); i++) begin
      chk("fifo_byte", 32'(dut_fifo[i]), 32'(exp_fifo[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
